// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the UART receive front end. Holds the
//               receiver state encoding, the data width and the divisor
//               helper functions used to size both baud tick generators.
//               The PARITY state only exists when UART_RX_PARITY_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_HOLD   = 3'd5
    } rx_state_e;

    // Transmit divisor: clock cycles per line bit, truncated, never below 1.
    function automatic int tx_divisor(input int clk_hz, input int baud);
        int d;
        d = clk_hz / baud;
        return (d < 1) ? 1 : d;
    endfunction

    // Receive divisor: clock cycles per oversample tick, truncated, never below 1.
    function automatic int rx_divisor(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running divider. Counts 0..DIV-1 and wraps; tick is
//               high for exactly the one clock cycle in which the count
//               equals DIV-1. The tick is registered so it is 0 in reset.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               tick  - one-cycle pulse every DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    generate
        if (DIV <= 1) begin : g_div_one
            // The count is permanently at its last value, so tick every cycle.
            logic r_tick;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_tick <= 1'b0;
                else        r_tick <= 1'b1;
            end
            assign tick = r_tick;
        end else begin : g_div_n
            localparam int                 c_CNT_W = $clog2(DIV);
            localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

            logic [c_CNT_W-1:0] r_cnt;
            logic               r_tick;
            logic [c_CNT_W-1:0] w_cnt_nxt;

            assign w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);

            // r_tick is precomputed from the next count so it is high in the
            // same cycle that r_cnt sits at DIV-1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_nxt;
                    r_tick <= (w_cnt_nxt == c_LAST);
                end
            end
            assign tick = r_tick;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frontend
// Description : UART receive front end with a companion transmit baud tick.
//               RX is double-flopped, then an oversampling state machine
//               (advanced only on the receive tick) centres on the start bit,
//               shifts in 8 data bits LSB first and checks the stop bit.
//               A completed frame is held (done=1) until run drops.
//               Optional feature macro: UART_RX_PARITY_EN adds an even parity
//               bit after the data bits; without it frames are 8N1 and
//               parity_err is tied 0.
// Ports       : CLKIN        - sole clock, rising edge
//               RESETN       - asynchronous active-low reset
//               RX           - asynchronous serial line, idle high
//               run          - receive enable (level)
//               data         - last received byte
//               done         - frame complete (level, held until run=0)
//               frame_err    - stop bit sampled low in the completed frame
//               parity_err   - parity mismatch in the completed frame
//               baud_tx_tick - one-cycle pulse at the line bit rate
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frontend
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                CLKIN,
    input  logic                RESETN,
    input  logic                RX,
    input  logic                run,
    output logic [c_DATA_W-1:0] data,
    output logic                done,
    output logic                frame_err,
    output logic                parity_err,
    output logic                baud_tx_tick
);

    localparam int c_TX_DIV = tx_divisor(CLK_HZ, BAUD);
    localparam int c_RX_DIV = rx_divisor(CLK_HZ, BAUD, OVERSAMPLE);

    localparam int                  c_TCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [c_TCNT_W-1:0] c_HALF_LAST = c_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TCNT_W-1:0] c_FULL_LAST = c_TCNT_W'(OVERSAMPLE - 1);
    localparam int                  c_BCNT_W    = $clog2(c_DATA_W);
    localparam logic [c_BCNT_W-1:0] c_BIT_LAST  = c_BCNT_W'(c_DATA_W - 1);

    logic                w_rx_tick;
    logic                r_rx_meta;
    logic                r_rx_sync;
    rx_state_e           r_state;
    logic [c_TCNT_W-1:0] r_tick_cnt;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [c_DATA_W-1:0] r_shift;
    logic [c_DATA_W-1:0] r_data;
    logic                r_done;
    logic                r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                r_par_bit;
    logic                r_parity_err;
`endif

    baud_tick_gen #(.DIV(c_TX_DIV)) u_tx_tick (
        .clk   (CLKIN),
        .rst_n (RESETN),
        .tick  (baud_tx_tick)
    );

    baud_tick_gen #(.DIV(c_RX_DIV)) u_rx_tick (
        .clk   (CLKIN),
        .rst_n (RESETN),
        .tick  (w_rx_tick)
    );

    // Synchronizer resets to the idle line level so no false start appears.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_tick && run && !r_done && !r_rx_sync) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                    end
                end

                // Half a bit in: still low means a real start bit.
                ST_START: begin
                    if (!run) begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_rx_tick) begin
                        if (r_tick_cnt == c_HALF_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (!run) begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_rx_tick) begin
                        if (r_tick_cnt == c_FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_sync, r_shift[c_DATA_W-1:1]};
                            if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!run) begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_rx_tick) begin
                        if (r_tick_cnt == c_FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_bit  <= r_rx_sync;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
                        end
                    end
                end
`endif

                // Results are published together, one cycle after the stop sample.
                ST_STOP: begin
                    if (!run) begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_rx_tick) begin
                        if (r_tick_cnt == c_FULL_LAST) begin
                            r_tick_cnt  <= '0;
                            r_data      <= r_shift;
                            r_frame_err <= ~r_rx_sync;
                            r_done      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
                            r_state     <= ST_HOLD;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
                        end
                    end
                end

                // Line activity is ignored until the consumer drops run.
                ST_HOLD: begin
                    if (!run) begin
                        r_done      <= 1'b0;
                        r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= 1'b0;
`endif
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign done      = r_done;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frontend
// Description : Directed self-checking bench for uart_rx_frontend at
//               3.6864 MHz / 115200 baud (32 cycles per bit, rx tick every
//               2 cycles). Expected frame results are queued when a frame is
//               driven and popped when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;
    import uart_rx_pkg::*;

    localparam int c_CLK_HZ  = 3686400;
    localparam int c_BAUD    = 115200;
    localparam int c_BIT_CYC = 32;
`ifdef UART_RX_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       CLKIN  = 1'b0;
    logic       RESETN = 1'b0;
    logic       RX     = 1'b1;
    logic       run    = 1'b0;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       parity_err;
    logic       baud_tx_tick;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 CLKIN = ~CLKIN;

    uart_rx_frontend #(
        .CLK_HZ     (c_CLK_HZ),
        .BAUD       (c_BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .CLKIN        (CLKIN),
        .RESETN       (RESETN),
        .RX           (RX),
        .run          (run),
        .data         (data),
        .done         (done),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .baud_tx_tick (baud_tx_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLKIN);
    endtask

    function automatic logic tick_of(input bit sel_rx);
        return sel_rx ? dut.w_rx_tick : baud_tx_tick;
    endfunction

    // Cycles between consecutive pulses; a missing pulse reports 0.
    task automatic measure_period(input string tag, input bit sel_rx, input int exp);
        int n;
        n = 0;
        while (tick_of(sel_rx) !== 1'b1 && n < 100) begin
            @(negedge CLKIN);
            n++;
        end
        n = 0;
        do begin
            @(negedge CLKIN);
            n++;
        end while (tick_of(sel_rx) !== 1'b1 && n < 100);
        check(tag, (n >= 100) ? 0 : n, exp);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        cycles(c_BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (c_PAR_EN) send_bit(par);
        send_bit(stop);
        RX = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.perr = c_PAR_EN ? ((^d) ^ par) : 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic expect_frame(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge CLKIN);
            n++;
        end
        check({tag, " done"}, done, 1);
        e = sb_q.pop_front();
        check({tag, " data"}, data, e.data);
        check({tag, " frame_err"}, frame_err, e.ferr);
        check({tag, " parity_err"}, parity_err, e.perr);
    endtask

    initial begin
        // Reset state, observed while RESETN is still low.
        cycles(3);
        check("rst data", data, 8'h00);
        check("rst done", done, 0);
        check("rst frame_err", frame_err, 0);
        check("rst parity_err", parity_err, 0);
        check("rst tx_tick", baud_tx_tick, 0);
        check("rst rx_tick", dut.w_rx_tick, 0);
        check("rst state", dut.r_state, ST_IDLE);
        RESETN = 1'b1;

        measure_period("tx tick period", 1'b0, 32);
        measure_period("rx tick period", 1'b1, 2);

        // Normal 8N1 frame, then hold behaviour.
        run = 1'b1;
        cycles(5);
        push_exp(8'hA5, ^8'hA5, 1'b1);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        expect_frame("a5");
        cycles(40);
        check("a5 done held", done, 1);
        send_frame(8'h11, ^8'h11, 1'b1);
        cycles(10);
        check("hold ignores data", data, 8'hA5);
        check("hold ignores done", done, 1);
        run = 1'b0;
        @(negedge CLKIN);
        check("release done", done, 0);
        check("release data", data, 8'hA5);
        check("release frame_err", frame_err, 0);
        check("release state", dut.r_state, ST_IDLE);

        // Abort during bit 3 of 0x3C (bits 0..3 = 0,0,1,1).
        run = 1'b1;
        cycles(5);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        RX = 1'b1;
        cycles(16);
        run = 1'b0;
        @(negedge CLKIN);
        check("abort state", dut.r_state, ST_IDLE);
        check("abort done", done, 0);
        check("abort data", data, 8'hA5);
        cycles(c_BIT_CYC * 12);
        run = 1'b1;
        cycles(5);
        push_exp(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        expect_frame("3c");
        run = 1'b0;
        cycles(2);
        check("3c release done", done, 0);

        // Stop bit low: still completes, with frame_err.
        run = 1'b1;
        cycles(5);
        push_exp(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        expect_frame("ferr");
        run = 1'b0;
        cycles(2);
        check("ferr release frame_err", frame_err, 0);
        check("ferr release data", data, 8'h00);

        // Short glitch must be rejected by the start-bit check.
        run = 1'b1;
        cycles(5);
        RX = 1'b0;
        cycles(4);
        RX = 1'b1;
        cycles(200);
        check("glitch done", done, 0);
        check("glitch data", data, 8'h00);
        check("glitch state", dut.r_state, ST_IDLE);

`ifdef UART_RX_PARITY_EN
        push_exp(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        expect_frame("par0");
        run = 1'b0;
        cycles(2);
        check("par0 release parity_err", parity_err, 0);
        run = 1'b1;
        cycles(5);
        push_exp(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        expect_frame("par1");
        run = 1'b0;
        cycles(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
